// File: rtl/dmem_lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_lsu_ctrl_if
// Bundles the signals between the load/store controller and its environment.
// The environment is the core LSU on one side and the word-wide synchronous
// data memory on the other.
//
// Core request side:
//   i_req, i_we, i_funct3[2:0], i_addr[31:0], i_wdata[31:0]  -> controller
//   o_ready, o_rvalid, o_rdata[31:0], o_done, o_err          <- controller
// Memory side:
//   o_mem_addr[31:0], o_mem_wdata[31:0], o_mem_wren          <- controller
//   i_mem_rdata[31:0]                                        -> controller
//
// Modports:
//   master : the environment (core + memory), drives the i_* signals.
//   slave  : the controller, drives the o_* signals.
// -----------------------------------------------------------------------------
interface dmem_lsu_ctrl_if;
    logic        i_req;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_rvalid;
    logic [31:0] o_rdata;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_mem_wren;
    logic [31:0] i_mem_rdata;

    modport master (
        output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
        input  o_ready, o_rvalid, o_rdata, o_done, o_err,
               o_mem_addr, o_mem_wdata, o_mem_wren
    );

    modport slave (
        input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
        output o_ready, o_rvalid, o_rdata, o_done, o_err,
               o_mem_addr, o_mem_wdata, o_mem_wren
    );
endinterface

// File: rtl/dmem_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_lsu_ctrl
// Load/store sequencer between the core LSU and a word-only data memory with
// registered (one-cycle) read data and write-on-edge.
//   - LB/LH/LW/LBU/LHU: read word, extract lane, sign/zero extend.
//   - SW: single write cycle.
//   - SB/SH: read-modify-write (read word, merge lane, write back).
//   - Misaligned, illegal-funct3 and out-of-range requests complete with an
//     error pulse and never touch memory.
//
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous reset, active low
//   bus     : dmem_lsu_ctrl_if.slave (core request/response + memory port)
// Parameter:
//   MEM_WORDS : number of 32-bit words; valid byte addresses 0..MEM_WORDS*4-1
// -----------------------------------------------------------------------------
module dmem_lsu_ctrl #(
    parameter int MEM_WORDS = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    dmem_lsu_ctrl_if.slave  bus
);

    localparam logic [32:0] BYTE_LIMIT = 33'(MEM_WORDS) << 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LDR,
        ST_MRG,
        ST_WR,
        ST_ERR
    } state_t;

    state_t      state_reg;
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        rvalid_reg;
    logic        done_reg;
    logic        err_reg;
    logic [31:0] rdata_reg;

    // Request legality, evaluated on the live request so the decision is
    // made on the accept edge.
    logic req_err;
    always_comb begin
        req_err = 1'b0;
        case (bus.i_funct3)
            3'b011, 3'b110, 3'b111: req_err = 1'b1;
            default: ;
        endcase
        // Unsigned variants only exist for loads.
        if (bus.i_we && bus.i_funct3[2])
            req_err = 1'b1;
        // H and HU both have funct3[1:0] == 01.
        if ((bus.i_funct3[1:0] == 2'b01) && bus.i_addr[0])
            req_err = 1'b1;
        if ((bus.i_funct3 == 3'b010) && (bus.i_addr[1:0] != 2'b00))
            req_err = 1'b1;
        if ({1'b0, bus.i_addr} >= BYTE_LIMIT)
            req_err = 1'b1;
    end

    // Load lane extraction and extension from the memory read data.
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_sign;
    logic [31:0] ld_ext;
    always_comb begin
        ld_byte = bus.i_mem_rdata[{addr_reg[1:0], 3'b000} +: 8];
        ld_half = bus.i_mem_rdata[{addr_reg[1], 4'b0000} +: 16];
        ld_sign = 1'b0;
        ld_ext  = bus.i_mem_rdata;
        case (funct3_reg[1:0])
            2'b00: begin
                ld_sign = ~funct3_reg[2] & ld_byte[7];
                ld_ext  = {{24{ld_sign}}, ld_byte};
            end
            2'b01: begin
                ld_sign = ~funct3_reg[2] & ld_half[15];
                ld_ext  = {{16{ld_sign}}, ld_half};
            end
            default: ld_ext = bus.i_mem_rdata;
        endcase
    end

    // Sub-word store merge: each byte lane takes store data when it is the
    // addressed lane, otherwise keeps the word just read back.
    logic [31:0] merge_data;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_hit;
            logic [7:0] lane_src;
            assign lane_hit = (funct3_reg[1:0] == 2'b00)
                            ? (addr_reg[1:0] == 2'(gi))
                            : (addr_reg[1] == 1'(gi / 2));
            // SB always stores the low byte; SH places its low/high byte
            // into the even/odd lane of the selected half.
            assign lane_src = (funct3_reg[1:0] == 2'b00)
                            ? wdata_reg[7:0]
                            : wdata_reg[8 * (gi % 2) +: 8];
            assign merge_data[8 * gi +: 8] = lane_hit ? lane_src
                                                      : bus.i_mem_rdata[8 * gi +: 8];
        end
    endgenerate

    // Memory port is combinational from state so reset drops wren at once.
    assign bus.o_ready     = (state_reg == ST_IDLE);
    assign bus.o_mem_addr  = {addr_reg[31:2], 2'b00};
    assign bus.o_mem_wren  = (state_reg == ST_MRG) || (state_reg == ST_WR);
    assign bus.o_mem_wdata = (state_reg == ST_WR) ? wdata_reg : merge_data;
    assign bus.o_rvalid    = rvalid_reg;
    assign bus.o_done      = done_reg;
    assign bus.o_err       = err_reg;
    assign bus.o_rdata     = rdata_reg;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg  <= ST_IDLE;
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= 32'd0;
            wdata_reg  <= 32'd0;
            rvalid_reg <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            rdata_reg  <= 32'd0;
        end else begin
            rvalid_reg <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_req) begin
                        we_reg     <= bus.i_we;
                        funct3_reg <= bus.i_funct3;
                        addr_reg   <= bus.i_addr;
                        wdata_reg  <= bus.i_wdata;
                        if (req_err)
                            state_reg <= ST_ERR;
                        else if (bus.i_we && (bus.i_funct3 == 3'b010))
                            state_reg <= ST_WR;
                        else
                            state_reg <= ST_RD;
                    end
                end
                // Only loads and SB/SH pass through RD.
                ST_RD: state_reg <= we_reg ? ST_MRG : ST_LDR;
                ST_LDR: begin
                    rdata_reg  <= ld_ext;
                    rvalid_reg <= 1'b1;
                    done_reg   <= 1'b1;
                    state_reg  <= ST_IDLE;
                end
                ST_MRG, ST_WR: begin
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                ST_ERR: begin
                    done_reg  <= 1'b1;
                    err_reg   <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
